// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake plus the drive/return lines of the shared 4-bit adder slice.
// The slave side is the serial adder controller; the master side is its environment.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             valid_in;
    logic             ready_out;

    logic [3:0]       adder_a_out;
    logic [3:0]       adder_b_out;
    logic             adder_c_out;
    logic [3:0]       adder_sum_in;
    logic             adder_carry_in;

    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             sum_valid_out;
    logic             sum_ready_in;
    logic             busy_out;

    modport slave (
        input  a_in, b_in, c_in, valid_in,
        output ready_out,
        output adder_a_out, adder_b_out, adder_c_out,
        input  adder_sum_in, adder_carry_in,
        output sum_out, carry_out, sum_valid_out,
        input  sum_ready_in,
        output busy_out
    );

    modport master (
        output a_in, b_in, c_in, valid_in,
        input  ready_out,
        input  adder_a_out, adder_b_out, adder_c_out,
        output adder_sum_in, adder_carry_in,
        input  sum_out, carry_out, sum_valid_out,
        output sum_ready_in,
        input  busy_out
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands through one external 4-bit adder slice, LSB nibble first.
// Latency WIDTH/4 cycles after acceptance; result held in DONE until sum_ready_in.
module nibble_serial_adder #(
    parameter int WIDTH     = 16,
    parameter int NIB_CNT_W = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    nibble_serial_adder_if.slave bus
);
    localparam int                     NIBBLES  = WIDTH / 4;
    localparam logic [NIB_CNT_W-1:0]   NIB_LAST = NIB_CNT_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 carry_q, carry_d;
    logic [NIB_CNT_W-1:0] nib_q, nib_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cout_q, cout_d;

    logic                 in_idle, in_run, in_done;
    logic [WIDTH-1:0]     a_shift, b_shift;

    assign in_idle = (state_q == ST_IDLE);
    assign in_run  = (state_q == ST_RUN);
    assign in_done = (state_q == ST_DONE);

    assign a_shift = a_q >> {nib_q, 2'b00};
    assign b_shift = b_q >> {nib_q, 2'b00};

    // The slice is only fed while a nibble is actually being processed.
    always_comb begin
        bus.adder_a_out = 4'h0;
        bus.adder_b_out = 4'h0;
        bus.adder_c_out = 1'b0;
        if (in_run) begin
            bus.adder_a_out = a_shift[3:0];
            bus.adder_b_out = b_shift[3:0];
            bus.adder_c_out = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        nib_d   = nib_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.c_in;
                    nib_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (nib_q == NIB_CNT_W'(i)) begin
                        acc_d[4*i +: 4] = bus.adder_sum_in;
                    end
                end
                carry_d = bus.adder_carry_in;
                // Visible result only changes once the final nibble lands.
                if (nib_q == NIB_LAST) begin
                    sum_d   = acc_d;
                    cout_d  = bus.adder_carry_in;
                    state_d = ST_DONE;
                end else begin
                    nib_d = nib_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.sum_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            nib_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            nib_q   <= nib_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.ready_out     = in_idle;
    assign bus.busy_out      = in_run;
    assign bus.sum_valid_out = in_done;
    assign bus.sum_out       = sum_q;
    assign bus.carry_out     = cout_q;
endmodule
